// File: rtl/n4_serial_subtractor_ctrl_pkg.sv
// n4_serial_subtractor_ctrl_pkg: FSM encoding, nibble width and counter sizing helper.
// Rev 1.0
`default_nettype none
package n4_serial_subtractor_ctrl_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Returns the ceiling of log2(n), never less than 1 bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/n4_serial_subtractor_ctrl_if.sv
// n4_serial_subtractor_ctrl_if: start/ready/done request bus; zero present with SERIAL_SUB_ZERO_EN.
// Rev 1.0
`default_nettype none
interface n4_serial_subtractor_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         bin;
  logic         ready;
  logic [W-1:0] d;
  logic         bout;
  logic         done;
`ifdef SERIAL_SUB_ZERO_EN
  logic         zero;

  modport master (output start, x, y, bin, input ready, d, bout, done, zero);
  modport slave  (input start, x, y, bin, output ready, d, bout, done, zero);
`else
  modport master (output start, x, y, bin, input ready, d, bout, done);
  modport slave  (input start, x, y, bin, output ready, d, bout, done);
`endif

endinterface
`default_nettype wire

// File: rtl/n4_b2_subtractor.sv
// n4_b2_subtractor: 4-bit base-2 subtractor slice, diff = a - b - bin with borrow out.
// Rev 1.0
`default_nettype none
module n4_b2_subtractor (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       bin_i,
  output logic [3:0] diff_o,
  output logic       bout_o
);
  logic [4:0] wide_w;

  // A negative result wraps modulo 32, so bit 4 is exactly the borrow.
  assign wide_w = {1'b0, a_i} - {1'b0, b_i} - {4'b0, bin_i};
  assign diff_o = wide_w[3:0];
  assign bout_o = wide_w[4];

endmodule
`default_nettype wire

// File: rtl/n4_serial_subtractor_ctrl.sv
// n4_serial_subtractor_ctrl: wide X - Y - bin computed one nibble per clock, LSB first.
// Optional feature macro: SERIAL_SUB_ZERO_EN (adds zero output). Rev 1.0
`default_nettype none
module n4_serial_subtractor_ctrl
  import n4_serial_subtractor_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  n4_serial_subtractor_ctrl_if.slave bus
);
  localparam int            W    = NIB_W * NIBBLES;
  localparam int            CW   = clog2_min1(NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  state_e           state_q, state_d;
  logic [W-1:0]     xs_q, ys_q, d_q;
  logic [CW-1:0]    cnt_q;
  logic             borrow_q, bout_q;
  logic [NIB_W-1:0] diff_w;
  logic             slice_bout_w;
  logic [W-1:0]     d_shift_w;
  logic             accept_w;
  logic             run_w;

  assign accept_w = (state_q == ST_IDLE) && bus.start;
  assign run_w    = (state_q == ST_RUN);

  n4_b2_subtractor u_slice (
    .a_i    (xs_q[NIB_W-1:0]),
    .b_i    (ys_q[NIB_W-1:0]),
    .bin_i  (borrow_q),
    .diff_o (diff_w),
    .bout_o (slice_bout_w)
  );

  // Each new digit enters at the top so the LSB digit lands at bit 0 after the last step.
  generate
    if (NIBBLES == 1) begin : g_single
      assign d_shift_w = diff_w;
    end else begin : g_multi
      assign d_shift_w = {diff_w, d_q[W-1:NIB_W]};
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_RUN;
      ST_RUN:  if (cnt_q == LAST) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.ready = (state_q == ST_IDLE);
    bus.done  = (state_q == ST_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      xs_q     <= '0;
      ys_q     <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
    end else if (accept_w) begin
      xs_q     <= bus.x;
      ys_q     <= bus.y;
      borrow_q <= bus.bin;
      cnt_q    <= '0;
    end else if (run_w) begin
      d_q      <= d_shift_w;
      xs_q     <= xs_q >> NIB_W;
      ys_q     <= ys_q >> NIB_W;
      borrow_q <= slice_bout_w;
      cnt_q    <= cnt_q + CW'(1);
      if (cnt_q == LAST) bout_q <= slice_bout_w;
    end
  end

  assign bus.d    = d_q;
  assign bus.bout = bout_q;

`ifdef SERIAL_SUB_ZERO_EN
  logic zacc_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)         zacc_q <= 1'b0;
    else if (accept_w) zacc_q <= 1'b1;
    else if (run_w)    zacc_q <= zacc_q & (diff_w == '0);
  end

  assign bus.zero = zacc_q;
`endif

endmodule
`default_nettype wire

// File: doc/n4_serial_subtractor_ctrl.md
# n4_serial_subtractor_ctrl

Sequential controller that performs a wide subtraction X − Y − bin using a single 4-bit base-2 subtractor slice. It processes one nibble per clock, least significant first, and chains the borrow through a register between steps. It sits between a requester using a start/ready/done handshake and one instance of the 4-bit subtractor datapath. This trades latency for area against a fully unrolled wide subtractor.

## Interface
Parameters:
- NIBBLES, 4, number of 4-bit digits processed; operand width W = 4·NIBBLES; legal range 1..16

Ports:
- clock  in  1  single system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only while ready=1
- x  in  W  minuend, sampled on accepted start
- y  in  W  subtrahend, sampled on accepted start
- bin  in  1  incoming borrow, sampled on accepted start
- ready  out  1  high in IDLE only
- d  out  W  difference; valid from done pulse until next accepted start
- bout  out  1  final borrow out of the top nibble; same validity as d
- done  out  1  one-cycle pulse; result valid
- zero  out  1  d == 0 (present only with SERIAL_SUB_ZERO_EN)

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: ready=1. When start=1, latch x→xs and y→ys (shift registers), bin→borrow register, cnt←0, and go to RUN.
- RUN: the datapath slice takes xs[3:0], ys[3:0] and the borrow register. On each edge:
  - The 4-bit difference shifts into d from the top: d ← {diff, d[W-1:4]}.
  - xs and ys shift right by 4.
  - Borrow register ← slice bout.
  - cnt++.
- RUN exit: when cnt == NIBBLES−1, that step completes, bout ← slice bout, and the FSM goes to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. ready=0 in DONE, so start is ignored that cycle.
- d and bout are not visible mid-RUN. During RUN they hold partial or previous contents, and consumers must qualify them with done. After DONE they hold until the next accepted start.
- start while ready=0 is ignored and not queued.
- x, y and bin may change freely after acceptance. Only the latched copies are used.
- Arithmetic is modulo 2^W. bout=1 iff X < Y + bin as unsigned values.
- cnt width is clog2(NIBBLES), with a minimum of 1 bit.
- Reset, including mid-RUN: state←IDLE, d←0, bout←0, done←0, cnt←0, borrow←0, xs/ys←0; ready=1 in the cycle after reset deasserts. An in-flight operation is discarded.
- Reset has priority over start in the same cycle.

## Timing
- Accepted start at edge k puts the FSM in RUN from k to k+NIBBLES−1.
- DONE is entered at edge k+NIBBLES, so done is high in the cycle after edge k+NIBBLES.
- ready returns high one cycle after done, giving a throughput of one operation per NIBBLES+2 cycles.
- Example with NIBBLES=4: start sampled at edge 0, done high in the cycle following edge 4, ready high after edge 5.
- The critical path is a single 4-bit slice plus the borrow register. No path grows with NIBBLES.
- ready and done are registered state decodes. They have no combinational path from start.

## Configuration
- SERIAL_SUB_ZERO_EN defined:
  - Adds the zero output and a sticky zero-accumulator register.
  - The accumulator is set to 1 on accepted start and ANDed with (diff == 0) each RUN step.
  - zero is valid with done and holds like d.
  - Reset value is 0.
- SERIAL_SUB_ZERO_EN undefined: no zero port and no accumulator register. All other behaviour is identical.

## Structure
- Shared package holds:
  - FSM state encoding IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - The nibble width constant 4.
  - The clog2 helper used for cnt sizing.
- One sub-module instance is natural: n4_b2_subtractor, driven with the low nibbles of xs/ys and the borrow register. Controller logic is kept outside it.

## Test plan
- NIBBLES=4, x=0x1234, y=0x0FFF, bin=0 → d=0x0235, bout=0, done high in the cycle after edge 4 from start.
- x=0x0000, y=0x0001, bin=0 → d=0xFFFF, bout=1; with the macro defined, zero=0.
- x=0x8000, y=0x0000, bin=1 → d=0x7FFF, bout=0, which exercises borrow rippling across all nibbles.
- Assert start again during RUN with different operands → ignored; first result 0x0235 unaffected, and exactly one done pulse.
- Assert reset at cycle 2 of RUN → ready=1 next cycle, d=0, bout=0, no done pulse. A fresh x=0xABCD, y=0xABCD then gives d=0x0000, bout=0, and zero=1 with the macro defined.
- NIBBLES=1, x=0x3, y=0x5 → d=0xE, bout=1, done in the cycle after edge 1.
